button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000; consecutive clk cycles a synchronised level must hold before it is accepted (10 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter TICK_DIV, default 1666668; clk cycles per game tick (about 60 Hz at 100 MHz); legal range 2..2^21.
REQ-003 SHALL have port clk, input, 1 bit; 100 MHz board clock; the only clock.
REQ-004 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have ports up, down, left, right, centre, each input, 1 bit; raw asynchronous push-button levels, active-high.
REQ-006 SHALL have ports up_db, down_db, left_db, right_db, centre_db, each output, 1 bit; debounced button levels.
REQ-007 SHALL have port game_tick, output, 1 bit; one-cycle pulse every TICK_DIV cycles; game logic updates only on this pulse.
REQ-008 SHALL have ports move_up, move_down, move_left, move_right, each output, 1 bit; direction commands sampled at game_tick and held until the next game_tick.
REQ-009 SHALL have port restart_req, output, 1 bit; one-cycle pulse coincident with game_tick when a centre press occurred during the elapsed tick period.

Function
REQ-010 SHALL pass each raw input through a two-flop synchroniser before any other use.
REQ-011 SHALL keep, per button, a stable level and a counter; counter clears whenever the synchronised level equals the stable level.
REQ-012 SHALL increment the counter while the synchronised level differs from the stable level, and SHALL toggle the stable level and clear the counter on the cycle the counter equals DEBOUNCE_CYCLES-1.
REQ-013 SHALL make an input change held continuously appear on *_db exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples the new raw level.
REQ-014 SHALL ignore any glitch shorter than DEBOUNCE_CYCLES synchronised cycles; *_db SHALL NOT change.
REQ-015 SHALL run a free-running tick counter 0..TICK_DIV-1 that wraps to 0, with game_tick high exactly in the cycle the counter equals TICK_DIV-1.
REQ-016 SHALL, on the game_tick cycle, register move_up = up_db AND NOT down_db, move_down = down_db AND NOT up_db, move_left = left_db AND NOT right_db, and move_right = right_db AND NOT left_db, so that opposite directions cancel.
REQ-017 SHALL hold move_* constant between game_tick pulses regardless of *_db activity.
REQ-018 SHALL set a sticky press flag on the rising edge of centre_db (0 to 1); restart_req SHALL equal game_tick AND (flag OR rising edge in the same cycle), and the flag SHALL clear on every game_tick.
REQ-019 SHALL generate at most one restart_req per tick period however many centre presses occur.
REQ-020 SHALL NOT let a held centre produce a restart_req on later ticks; only a new rising edge does.
REQ-021 SHALL NOT let a falling edge of centre_db set the flag.
REQ-022 SHALL contain no combinational path from any raw input to any output.

Reset
REQ-023 SHALL, while reset is high at a clk edge, clear synchronisers, stable levels, debounce counters, the tick counter and the press flag to 0.
REQ-024 SHALL drive every output to 0 during reset and in the first cycle after reset.
REQ-025 SHALL NOT register a press for a button held through reset until it has been debounced high after reset; its rising edge then counts as a new press.
REQ-026 SHALL, on reset asserted mid-debounce or mid-tick, abandon the partial count; counting restarts from 0 after reset.

Structure
REQ-027 SHALL place the default values of DEBOUNCE_CYCLES and TICK_DIV and the button index constants (UP=0, DOWN=1, LEFT=2, RIGHT=3, CENTRE=4) in the shared game package.
REQ-028 SHALL implement synchroniser plus debouncer as one sub-module, debounce, instantiated five times; tick, direction and restart logic SHALL stay in the top level.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-029 SHALL cover: up held high from edge 0 -> up_db rises at edge 6 and stays high; a 3-cycle up pulse -> up_db never rises.
REQ-030 SHALL cover: no input after reset release -> game_tick high at counter 9, then every 10 cycles, one cycle wide.
REQ-031 SHALL cover: up_db and down_db both high at a tick -> move_up=0 and move_down=0; release down -> move_up=1 from the next tick only.
REQ-032 SHALL cover: two centre presses inside one tick period -> exactly one restart_req, on that tick; centre held for 3 ticks -> one restart_req total.
REQ-033 SHALL cover: centre_db rising in the same cycle as game_tick -> restart_req=1 on that cycle and the flag clear afterwards.
REQ-034 SHALL cover: reset pulsed while left is debouncing at counter 2 -> left_db=0 and all outputs 0; left_db rises 6 edges after reset release with left still held.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared game package: default timing parameters and button indices.
// Imported by the conditioner top and its debounce sub-module.
package button_conditioner_pkg;

    // 10 ms debounce window at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    // ~60 Hz game tick at 100 MHz
    localparam int unsigned TICK_DIV_DEF = 1666668;

    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned UP     = 0;
    localparam int unsigned DOWN   = 1;
    localparam int unsigned LEFT   = 2;
    localparam int unsigned RIGHT  = 3;
    localparam int unsigned CENTRE = 4;

endpackage

// File: rtl/button_conditioner_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw button.
// Ports: clk, reset (sync, active-high), raw_i (async level), db_o (debounced level).
module debounce
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;

    // Counter only advances while the synchronised level disagrees with the
    // accepted level; any agreement (a glitch ending) restarts the window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // db_q is a registered copy of the stable level so the output
    // never depends combinationally on the debounce decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            db_q     <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            db_q     <= stable_q;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces five push-buttons, derives a game tick, tick-sampled direction
// commands and a once-per-tick restart request. Ports: clk, reset, raw
// buttons in; *_db levels, game_tick, move_*, restart_req out.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    input  logic centre,
    output logic up_db,
    output logic down_db,
    output logic left_db,
    output logic right_db,
    output logic centre_db,
    output logic game_tick,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic restart_req
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] db;

    assign raw[UP]     = up;
    assign raw[DOWN]   = down;
    assign raw[LEFT]   = left;
    assign raw[RIGHT]  = right;
    assign raw[CENTRE] = centre;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw_i(raw[i]),
            .db_o (db[i])
        );
    end

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic          tick_hit;
    logic [3:0]    move_q;
    logic [3:0]    move_d;
    logic          centre_prev_q;
    logic          flag_q;
    logic          flag_d;
    logic          centre_rise;

    assign tick_hit    = (tick_q == TICK_LAST);
    assign centre_rise = db[CENTRE] & ~centre_prev_q;

    always_comb begin
        tick_d = tick_hit ? '0 : tick_q + 1'b1;
        move_d = move_q;
        flag_d = flag_q;
        if (tick_hit) begin
            // Opposite directions cancel each other.
            move_d[UP]    = db[UP] & ~db[DOWN];
            move_d[DOWN]  = db[DOWN] & ~db[UP];
            move_d[LEFT]  = db[LEFT] & ~db[RIGHT];
            move_d[RIGHT] = db[RIGHT] & ~db[LEFT];
            // A press landing on the tick itself is consumed by this tick.
            flag_d        = 1'b0;
        end else if (centre_rise) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q        <= '0;
            move_q        <= '0;
            centre_prev_q <= 1'b0;
            flag_q        <= 1'b0;
        end else begin
            tick_q        <= tick_d;
            move_q        <= move_d;
            centre_prev_q <= db[CENTRE];
            flag_q        <= flag_d;
        end
    end

    assign up_db       = db[UP];
    assign down_db     = db[DOWN];
    assign left_db     = db[LEFT];
    assign right_db    = db[RIGHT];
    assign centre_db   = db[CENTRE];
    assign game_tick   = tick_hit & ~reset;
    assign restart_req = tick_hit & ~reset & (flag_q | centre_rise);
    assign move_up     = move_q[UP];
    assign move_down   = move_q[DOWN];
    assign move_left   = move_q[LEFT];
    assign move_right  = move_q[RIGHT];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed-vector bench for button_conditioner.
// Runs with DEBOUNCE_CYCLES=4, TICK_DIV=10.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic up = 1'b0;
    logic down = 1'b0;
    logic left = 1'b0;
    logic right = 1'b0;
    logic centre = 1'b0;
    logic up_db, down_db, left_db, right_db, centre_db;
    logic game_tick, restart_req;
    logic move_up, move_down, move_left, move_right;
    logic [10:0] outs;

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .up(up),
        .down(down),
        .left(left),
        .right(right),
        .centre(centre),
        .up_db(up_db),
        .down_db(down_db),
        .left_db(left_db),
        .right_db(right_db),
        .centre_db(centre_db),
        .game_tick(game_tick),
        .move_up(move_up),
        .move_down(move_down),
        .move_left(move_left),
        .move_right(move_right),
        .restart_req(restart_req)
    );

    assign outs = {up_db, down_db, left_db, right_db, centre_db,
                   game_tick, move_up, move_down, move_left,
                   move_right, restart_req};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // cyc counts edges after release, so the tick counter equals cyc mod 10.
    task automatic do_reset();
        reset = 1'b1;
        {up, down, left, right, centre} = '0;
        step(2);
        chk("rst_outs", outs, 0);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Held up: first sampling edge is cyc 1, up_db rises 6 edges later.
        do_reset();
        up = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step(1);
            chk("hold_up_db", up_db, cyc >= 7);
            chk("tick_period", game_tick, (cyc % 10) == 9);
            chk("move_up_held", move_up, cyc >= 10);
            chk("no_restart", restart_req, 0);
        end

        // 3-cycle glitch must be ignored.
        do_reset();
        up = 1'b1;
        step(1);
        chk("first_cycle_outs", outs, 0);
        step(2);
        up = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("glitch_up_db", up_db, 0);
        end

        // Opposite directions cancel; release down takes effect next tick.
        do_reset();
        {up, down, left, right} = 4'b1111;
        step(10);
        chk("both_up_db", up_db, 1);
        chk("both_down_db", down_db, 1);
        chk("cancel_up", move_up, 0);
        chk("cancel_down", move_down, 0);
        chk("cancel_left", move_left, 0);
        chk("cancel_right", move_right, 0);
        down = 1'b0;
        left = 1'b0;
        step(8);
        chk("down_db_fell", down_db, 0);
        chk("hold_between_up", move_up, 0);
        step(1);
        chk("tick19", game_tick, 1);
        chk("still_held_up", move_up, 0);
        step(1);
        chk("rel_move_up", move_up, 1);
        chk("rel_move_down", move_down, 0);
        chk("rel_move_right", move_right, 1);
        chk("rel_move_left", move_left, 0);

        // Two presses in one tick window, then held for later ticks.
        do_reset();
        for (int i = 0; i < 65; i++) begin
            step(1);
            if (cyc == 23) centre = 1'b1;
            if (cyc == 27) centre = 1'b0;
            if (cyc == 31) centre = 1'b1;
            if (cyc == 30) chk("press1_db", centre_db, 1);
            if (cyc == 34) chk("release1_db", centre_db, 0);
            if (cyc == 38) chk("press2_db", centre_db, 1);
            if (cyc == 60) chk("held_db", centre_db, 1);
            chk("restart_once", restart_req, cyc == 39);
        end

        // Rise coincides with tick; later falling edge must not request.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (cyc == 2) centre = 1'b1;
            if (cyc == 10) centre = 1'b0;
            step(1);
            if (cyc == 9) chk("coinc_db", centre_db, 1);
            if (cyc == 17) chk("fall_db", centre_db, 0);
            chk("restart_coinc", restart_req, cyc == 9);
        end

        // Reset mid-debounce (left counter at 2) abandons the count.
        do_reset();
        left = 1'b1;
        step(4);
        reset = 1'b1;
        step(1);
        chk("mid_rst_outs", outs, 0);
        chk("mid_rst_left", left_db, 0);
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (cyc == 1) chk("post_rst_outs", outs, 0);
            chk("left_after_rst", left_db, cyc >= 7);
            chk("tick_after_rst", game_tick, cyc == 9);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
